// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared FSM encodings, default widths and idle bus constants
// for the SRAM port arbiter.
package cpu_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam int DEFAULT_AW = 16;
  localparam int DEFAULT_DW = 16;

  // Wide enough for any practical AW/DW; users slice the low bits.
  localparam int               ONES_W    = 64;
  localparam logic [ONES_W-1:0] IDLE_ONES = '1;

endpackage

// File: rtl/arb_pick2.sv
// rtl/arb_pick2.sv - two-way winner select (grant: 0 = port 0, 1 = port 1).
// Tie policy set by SRAM_ARB_ROUND_ROBIN_EN; otherwise port 0 wins ties.
module arb_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic grant
);

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  assign grant = (req0 && req1) ? ~last : req1;
`else
  logic unused_last;
  assign unused_last = last;
  assign grant       = ~req0 & req1;
`endif

endmodule

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - arbitrates two requesters onto one SRAM port with a
// fixed ACC_CYCLES access window; tie policy via SRAM_ARB_ROUND_ROBIN_EN.
module sram_port_arbiter
  import cpu_pkg::*;
#(
  parameter int ACC_CYCLES = 1,
  parameter int AW         = DEFAULT_AW,
  parameter int DW         = DEFAULT_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0_n,
  input  logic          we1_n,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] sram_addr,
  output logic          sram_we_n,
  output logic [DW-1:0] sram_q,
  input  logic [DW-1:0] sram_d
);

  localparam logic [3:0] CNT_INIT = 4'(ACC_CYCLES - 1);

  logic [1:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          gnt_q, gnt_d;
  logic          last_q, last_d;
  logic          we_n_q, we_n_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          pick;
  logic          in_access;
  logic          in_done;

  arb_pick2 u_pick (
    .req0  (req0),
    .req1  (req1),
    .last  (last_q),
    .grant (pick)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    we_n_d  = we_n_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          gnt_d   = pick;
          last_d  = pick;
          we_n_d  = pick ? we1_n  : we0_n;
          addr_d  = pick ? addr1  : addr0;
          wdata_d = pick ? wdata1 : wdata0;
          cnt_d   = CNT_INIT;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_DONE;
          if (we_n_q) rdata_d = sram_d;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      we_n_q  <= 1'b1;
      addr_q  <= IDLE_ONES[AW-1:0];
      wdata_q <= IDLE_ONES[DW-1:0];
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      we_n_q  <= we_n_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Bus outputs decode straight from state so an async reset releases the SRAM at once.
  assign in_access = (state_q == ST_ACCESS);
  assign in_done   = (state_q == ST_DONE);
  assign sram_addr = in_access ? addr_q  : IDLE_ONES[AW-1:0];
  assign sram_q    = in_access ? wdata_q : IDLE_ONES[DW-1:0];
  assign sram_we_n = in_access ? we_n_q  : 1'b1;
  assign ack0      = in_done & ~gnt_q;
  assign ack1      = in_done &  gnt_q;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - directed bench for sram_port_arbiter; two instances
// (ACC_CYCLES=1 and 3) share stimulus. Tie expectations follow SRAM_ARB_ROUND_ROBIN_EN.
module tb_sram_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1, we0_n, we1_n;
  logic [15:0] addr0, addr1, wdata0, wdata1, sram_d;

  logic        d1_ack0, d1_ack1, d1_we_n;
  logic [15:0] d1_rdata, d1_addr, d1_q;
  logic        d3_ack0, d3_ack1, d3_we_n;
  logic [15:0] d3_rdata, d3_addr, d3_q;

  int checks   = 0;
  int failures = 0;
  int order   [4];
  int ack_cyc [4];
  int n_acks;
  int ack_sum;
  int exp_order [4];

  always #5 clk = ~clk;

  sram_port_arbiter #(.ACC_CYCLES(1), .AW(16), .DW(16)) u_dut1 (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .we0_n(we0_n), .we1_n(we1_n),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(d1_ack0), .ack1(d1_ack1), .rdata(d1_rdata), .sram_addr(d1_addr),
    .sram_we_n(d1_we_n), .sram_q(d1_q), .sram_d(sram_d)
  );

  sram_port_arbiter #(.ACC_CYCLES(3), .AW(16), .DW(16)) u_dut3 (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .we0_n(we0_n), .we1_n(we1_n),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(d3_ack0), .ack1(d3_ack1), .rdata(d3_rdata), .sram_addr(d3_addr),
    .sram_we_n(d3_we_n), .sram_q(d3_q), .sram_d(sram_d)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    exp_order = '{0, 1, 0, 1};
`else
    exp_order = '{0, 0, 0, 0};
`endif
    reset = 1'b0; req0 = 1'b0; req1 = 1'b0; we0_n = 1'b1; we1_n = 1'b1;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; sram_d = 16'h1234;
    #2;
    check("rst_we_n",  32'(d1_we_n), 32'd1);
    check("rst_addr",  32'(d1_addr), 32'hFFFF);
    check("rst_q",     32'(d1_q), 32'hFFFF);
    check("rst_acks",  32'({d1_ack0, d1_ack1}), 32'd0);
    check("rst_rdata", 32'(d1_rdata), 32'd0);
    step(); step();
    reset = 1'b1;
    step();

    // single read, fields changed after the latch edge
    req0 = 1'b1; we0_n = 1'b1; addr0 = 16'h0010;
    step();
    check("rd_c1_addr", 32'(d1_addr), 32'h0010);
    check("rd_c1_we_n", 32'(d1_we_n), 32'd1);
    check("rd_c1_acks", 32'({d1_ack0, d1_ack1}), 32'd0);
    addr0 = 16'hAAAA;
    step();
    check("rd_ack0",      32'(d1_ack0), 32'd1);
    check("rd_ack1",      32'(d1_ack1), 32'd0);
    check("rd_rdata",     32'(d1_rdata), 32'h1234);
    check("rd_idle_addr", 32'(d1_addr), 32'hFFFF);
    check("latch_hold",   32'(d3_addr), 32'h0010);
    req0 = 1'b0;
    step();
    check("rd3_c3_ack0", 32'(d3_ack0), 32'd0);
    step();
    check("rd3_ack0",  32'(d3_ack0), 32'd1);
    check("rd3_rdata", 32'(d3_rdata), 32'h1234);
    step(); step();

    // write window with ACC_CYCLES=3
    sram_d = 16'h0F0F;
    req1 = 1'b1; we1_n = 1'b0; addr1 = 16'h0020; wdata1 = 16'hBEEF;
    for (int c = 1; c <= 3; c++) begin
      step();
      check($sformatf("wr_c%0d_we_n", c), 32'(d3_we_n), 32'd0);
      check($sformatf("wr_c%0d_q", c),    32'(d3_q), 32'hBEEF);
      check($sformatf("wr_c%0d_addr", c), 32'(d3_addr), 32'h0020);
    end
    step();
    check("wr_ack1",       32'(d3_ack1), 32'd1);
    check("wr_ack0",       32'(d3_ack0), 32'd0);
    check("wr_we_n_done",  32'(d3_we_n), 32'd1);
    req1 = 1'b0;
    step();
    check("wr_we_n_idle",  32'(d3_we_n), 32'd1);
    check("wr_rdata_hold", 32'(d3_rdata), 32'h1234);
    step(); step();

    // ties held continuously on the ACC_CYCLES=1 instance
    sram_d = 16'h1234;
    req0 = 1'b1; req1 = 1'b1; we0_n = 1'b1; we1_n = 1'b1;
    n_acks = 0;
    for (int c = 1; c <= 20 && n_acks < 4; c++) begin
      step();
      if (d1_ack0 || d1_ack1) begin
        check($sformatf("tie_onehot_%0d", n_acks), 32'({d1_ack0, d1_ack1}) & 32'h3,
              d1_ack1 ? 32'd1 : 32'd2);
        order[n_acks]   = int'(d1_ack1);
        ack_cyc[n_acks] = c;
        n_acks++;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    check("tie_count", 32'(n_acks), 32'd4);
    if (n_acks == 4) begin
      for (int i = 0; i < 4; i++)
        check($sformatf("tie_order_%0d", i), 32'(order[i]), 32'(exp_order[i]));
      for (int i = 1; i < 4; i++)
        check($sformatf("b2b_gap_%0d", i), 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd3);
    end
    for (int i = 0; i < 6; i++) step();

    // reset in the middle of a write
    req0 = 1'b1; we0_n = 1'b0; addr0 = 16'h0030; wdata0 = 16'h5555;
    step();
    check("rw_c1_we_n", 32'(d3_we_n), 32'd0);
    #2 reset = 1'b0;
    #1;
    check("rw_async_we_n", 32'(d3_we_n), 32'd1);
    check("rw_async_addr", 32'(d3_addr), 32'hFFFF);
    req0 = 1'b0;
    step(); step();
    check("rw_rst_rdata", 32'(d3_rdata), 32'd0);
    reset = 1'b1;
    ack_sum = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      ack_sum += int'(d3_ack0) + int'(d3_ack1);
    end
    check("rw_no_ack", 32'(ack_sum), 32'd0);

    // a fresh read shows full latency, so the block sat in IDLE
    sram_d = 16'h7777;
    req0 = 1'b1; we0_n = 1'b1; addr0 = 16'h0040;
    step(); step(); step();
    check("post_c3_ack0", 32'(d3_ack0), 32'd0);
    step();
    check("post_ack0",  32'(d3_ack0), 32'd1);
    check("post_rdata", 32'(d3_rdata), 32'h7777);
    req0 = 1'b0;
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 Parameter ACC_CYCLES, default 1, number of cycles the SRAM is driven per access; legal range 1..15.
REQ-002 Parameter AW, default 16, SRAM address width.
REQ-003 Parameter DW, default 16, SRAM data width.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 req0 / req1  in  1 each  access request; port 0 is the CPU control FSM, port 1 is the loader/debug port.
REQ-007 we0_n / we1_n  in  1 each  per-port write enable, active-low (0 = write, 1 = read).
REQ-008 addr0 / addr1  in  AW each  per-port access address.
REQ-009 wdata0 / wdata1  in  DW each  per-port write data.
REQ-010 ack0 / ack1  out  1 each  one-cycle completion pulse to the granted port.
REQ-011 rdata  out  DW  read data; valid while the matching ack is high.
REQ-012 sram_addr  out  AW  SRAM address.
REQ-013 sram_we_n  out  1  SRAM write enable, active-low.
REQ-014 sram_q  out  DW  SRAM write data.
REQ-015 sram_d  in  DW  SRAM read data.

Function
REQ-016 The FSM SHALL have three states: IDLE, ACCESS, DONE.
- IDLE: if req0 or req1 is high, select a winner; latch its we_n, addr and wdata, load the cycle counter with ACC_CYCLES-1, and go to ACCESS. Otherwise stay in IDLE.
- ACCESS: decrement the counter each cycle; go to DONE when the counter is 0.
- DONE: always go to IDLE.
REQ-017 In ACCESS, sram_addr and sram_q SHALL carry the latched values, and sram_we_n SHALL equal the latched we_n. Outside ACCESS they SHALL be all-ones, all-ones and 1 respectively.
REQ-018 The read-data register SHALL capture sram_d on the final ACCESS cycle for reads only; it holds its value otherwise.
REQ-019 In DONE, exactly one ack SHALL be high: the one for the granted port. rdata SHALL show the captured data.
REQ-020 Latency: a request sampled in IDLE at edge N SHALL produce its ack during cycle N+ACC_CYCLES+1.
REQ-021 Requesters SHALL hold req and their request fields stable until ack. Changes to the request fields after the IDLE latch edge SHALL have no effect on the access in flight.
REQ-022 A req still high during DONE SHALL be treated as a new request at the next IDLE evaluation. There is always at least one IDLE cycle between accesses.
REQ-023 A req that drops before it is granted SHALL be ignored without error.
REQ-024 When only one req is high, that port SHALL win regardless of configuration.

Reset
REQ-025 While reset is low, the block SHALL be asynchronously forced to:
- state IDLE and counter 0;
- ack0 = ack1 = 0, rdata = 0;
- sram_we_n = 1, sram_addr and sram_q all-ones;
- last-grant flop = 1.
REQ-026 Reset during ACCESS SHALL abort the access and issue no ack. sram_we_n SHALL go high immediately, without waiting for a clock edge.

Configuration
REQ-027 With macro SRAM_ARB_ROUND_ROBIN_EN defined, on a simultaneous req0 and req1 the port not granted last SHALL win. The last-grant flop updates on every IDLE-to-ACCESS transition.
REQ-028 Without SRAM_ARB_ROUND_ROBIN_EN, port 0 SHALL always win ties. The last-grant flop SHALL still exist but SHALL not influence the selection.

Structure
REQ-029 The state enum (IDLE/ACCESS/DONE encodings), the default AW/DW values and the all-ones idle constants SHALL live in the shared package cpu_pkg.
REQ-030 Winner selection SHALL be a sub-module, arb_pick2, with inputs req0, req1 and last and output grant. It SHALL contain no other logic.

Verification
REQ-031 Single read: ACC_CYCLES=1, sram_d=16'h1234, req0 read addr 16'h0010 at edge 0 -> sram_addr=16'h0010 in cycle 1; ack0 and rdata=16'h1234 in cycle 2.
REQ-032 Write timing: ACC_CYCLES=3, req1 write addr 16'h0020 data 16'hBEEF -> sram_we_n=0 for exactly 3 cycles with sram_q=16'hBEEF; ack1 in cycle 4; sram_we_n=1 thereafter.
REQ-033 Tie, round robin on: req0 and req1 held high continuously -> grant order 0,1,0,1. Tie, macro off -> grant order 0,0,0.
REQ-034 Back-to-back: req0 held through DONE -> second access starts after exactly one IDLE cycle.
REQ-035 Reset mid-write: assert reset during ACCESS of a write -> sram_we_n=1 asynchronously, no ack pulse, and the block is in IDLE after reset releases.
